// File: rtl/meas_sequencer.sv
// Measurement sequencer: clears and gates an external edge counter, latches the count,
// then streams it as four big-endian bytes plus a newline to a UART transmitter.
module meas_sequencer #(
  parameter int unsigned GATE_CYCLES   = 100000000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             abort_i,
  output logic             cnt_clr_o,
  output logic             cnt_en_o,
  input  logic [CNT_W-1:0] cnt_val_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] last_count_o
);

  localparam int unsigned GateW   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GateW-1:0]   GateLast   = GateW'(GATE_CYCLES - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StGate, StSettle, StLatch, StSend, StDone
  } state_e;

  state_e             state_q;
  logic [GateW-1:0]   gate_cnt_q;
  logic [SettleW-1:0] settle_cnt_q;
  logic [2:0]         byte_idx_q;
  logic [7:0]         next_byte;

  // Byte that follows the one currently presented; index 0 is loaded directly in LATCH.
  always_comb begin
    next_byte = 8'h0A;
    case (byte_idx_q)
      3'd0:    next_byte = last_count_o[23:16];
      3'd1:    next_byte = last_count_o[15:8];
      3'd2:    next_byte = last_count_o[7:0];
      default: next_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      gate_cnt_q   <= '0;
      settle_cnt_q <= '0;
      byte_idx_q   <= '0;
      cnt_clr_o    <= 1'b0;
      cnt_en_o     <= 1'b0;
      tx_data_o    <= 8'h00;
      tx_valid_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      last_count_o <= '0;
    end else begin
      cnt_clr_o <= 1'b0;
      done_o    <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        state_q      <= StIdle;
        gate_cnt_q   <= '0;
        settle_cnt_q <= '0;
        byte_idx_q   <= '0;
        cnt_en_o     <= 1'b0;
        tx_valid_o   <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q   <= StClear;
              cnt_clr_o <= 1'b1;
              busy_o    <= 1'b1;
            end
          end
          StClear: begin
            state_q    <= StGate;
            gate_cnt_q <= '0;
            cnt_en_o   <= 1'b1;
          end
          StGate: begin
            if (gate_cnt_q == GateLast) begin
              gate_cnt_q   <= '0;
              settle_cnt_q <= '0;
              cnt_en_o     <= 1'b0;
              state_q      <= (SETTLE_CYCLES == 0) ? StLatch : StSettle;
            end else begin
              gate_cnt_q <= gate_cnt_q + 1'b1;
            end
          end
          StSettle: begin
            if (settle_cnt_q == SettleLast) begin
              settle_cnt_q <= '0;
              state_q      <= StLatch;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
          StLatch: begin
            last_count_o <= cnt_val_i;
            tx_data_o    <= cnt_val_i[31:24];
            tx_valid_o   <= 1'b1;
            byte_idx_q   <= '0;
            state_q      <= StSend;
          end
          StSend: begin
            // tx_valid_o is always high here, so ready alone marks a transfer.
            if (tx_ready_i) begin
              if (byte_idx_q == 3'd4) begin
                tx_valid_o <= 1'b0;
                byte_idx_q <= '0;
                done_o     <= 1'b1;
                state_q    <= StDone;
              end else begin
                byte_idx_q <= byte_idx_q + 3'd1;
                tx_data_o  <= next_byte;
              end
            end
          end
          StDone: begin
            if (cont_i) begin
              state_q   <= StClear;
              cnt_clr_o <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_o  <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed self-checking bench for meas_sequencer with a 10-cycle gate and 2-cycle settle.
module tb_meas_sequencer;

  localparam int unsigned G = 10;
  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        rst, start, cont, abort, tx_ready;
  logic [31:0] cnt_val;
  logic        cnt_clr, cnt_en, tx_valid, busy, done;
  logic [7:0]  tx_data;
  logic [31:0] last_count;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int en_n = 0, clr_n = 0, done_n = 0, done_at = 0;

  meas_sequencer #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .CNT_W        (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .cont_i      (cont),
    .abort_i     (abort),
    .cnt_clr_o   (cnt_clr),
    .cnt_en_o    (cnt_en),
    .cnt_val_i   (cnt_val),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .done_o      (done),
    .last_count_o(last_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive observer at mid-cycle: transfers, gate cycles, clear and done pulses.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) rx_q.push_back(tx_data);
    if (cnt_en) en_n++;
    if (cnt_clr) clr_n++;
    if (done) begin
      done_n++;
      done_at = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d required completion", checks);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int base, input int limit);
    int k = 0;
    while (done_n == base && k < limit) begin
      step(1);
      k++;
    end
    checks++;
    if (done_n == base)
      $display("FAIL wait_done: no done_o within %0d cycles, got %0d pulses required >%0d",
               limit, done_n, base);
    else passes++;
  endtask

  task automatic get_bytes(input int base, output logic [127:0] v, output int n);
    v = '0;
    n = rx_q.size() - base;
    for (int i = 0; i < n && i < 16; i++) v = {v[119:0], rx_q[base + i]};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++;
    if ({cnt_clr, cnt_en, tx_valid, busy, done} !== 5'b0)
      $display("FAIL reset_flags: clr/en/valid/busy/done=%b required 00000",
               {cnt_clr, cnt_en, tx_valid, busy, done});
    else passes++;
    checks++;
    if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h required 00", tx_data);
    else passes++;
    checks++;
    if (last_count !== 32'h0) $display("FAIL reset_last_count: got %h required 0", last_count);
    else passes++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single();
    int t0, b_en, b_clr, b_done, b_rx, n;
    logic [127:0] got;
    cnt_val = 32'h12345678;
    tx_ready = 1'b1;
    b_en = en_n; b_clr = clr_n; b_done = done_n; b_rx = rx_q.size();
    t0 = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (cnt_clr !== 1'b1 || busy !== 1'b1)
      $display("FAIL single_clear: cnt_clr=%b busy=%b required 1 1", cnt_clr, busy);
    else passes++;
    wait_done(b_done, 60);
    checks++;
    if (en_n - b_en != 10) $display("FAIL single_gate_len: got %0d required 10", en_n - b_en);
    else passes++;
    checks++;
    if (clr_n - b_clr != 1) $display("FAIL single_clr_len: got %0d required 1", clr_n - b_clr);
    else passes++;
    get_bytes(b_rx, got, n);
    checks++;
    if (n != 5 || got[39:0] !== 40'h12345678_0A)
      $display("FAIL single_bytes: got %0d bytes %h required 5 bytes 123456780a", n, got[39:0]);
    else passes++;
    checks++;
    if (done_at - t0 != 20) $display("FAIL single_latency: got %0d required 20", done_at - t0);
    else passes++;
    checks++;
    if (last_count !== 32'h12345678)
      $display("FAIL single_last_count: got %h required 12345678", last_count);
    else passes++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL single_idle: busy=%b done=%b required 0 0", busy, done);
    else passes++;
  endtask

  task automatic test_backpressure();
    int t0, b_done, b_rx, n, held;
    logic [127:0] got;
    cnt_val = 32'hA534C7E1;
    tx_ready = 1'b1;
    b_done = done_n; b_rx = rx_q.size();
    t0 = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(15);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h34)
      $display("FAIL bp_second_byte: valid=%b data=%h required 1 34", tx_valid, tx_data);
    else passes++;
    tx_ready = 1'b0;
    held = 0;
    repeat (7) begin
      if (tx_valid === 1'b1 && tx_data === 8'h34) held++;
      step(1);
    end
    tx_ready = 1'b1;
    wait_done(b_done, 60);
    checks++;
    if (held != 7) $display("FAIL bp_hold: stable cycles %0d required 7", held);
    else passes++;
    get_bytes(b_rx, got, n);
    checks++;
    if (n != 5 || got[39:0] !== 40'hA534C7E1_0A)
      $display("FAIL bp_bytes: got %0d bytes %h required 5 bytes a534c7e10a", n, got[39:0]);
    else passes++;
    checks++;
    if (done_at - t0 != 27) $display("FAIL bp_latency: got %0d required 27", done_at - t0);
    else passes++;
  endtask

  task automatic test_continuous();
    int t0, b_done, b_clr, b_rx, n, busy_low;
    logic clr_at21;
    logic [127:0] got;
    tx_ready = 1'b1;
    cont = 1'b1;
    b_done = done_n; b_clr = clr_n; b_rx = rx_q.size();
    busy_low = 0;
    clr_at21 = 1'b0;
    t0 = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      cnt_val = 32'h100 + 32'(k / 20);
      if (k == 45) cont = 1'b0;
      if (k <= 60 && busy !== 1'b1) busy_low++;
      if (k == 21) clr_at21 = cnt_clr;
      step(1);
    end
    checks++;
    if (done_n - b_done != 3) $display("FAIL cont_frames: got %0d required 3", done_n - b_done);
    else passes++;
    checks++;
    if (clr_at21 !== 1'b1 || busy_low != 0)
      $display("FAIL cont_no_idle: clr_at21=%b busy_low=%0d required 1 0", clr_at21, busy_low);
    else passes++;
    checks++;
    if (done_at - t0 != 60) $display("FAIL cont_last_done: got %0d required 60", done_at - t0);
    else passes++;
    get_bytes(b_rx, got, n);
    checks++;
    if (n != 15 || got[119:0] !== 120'h00000100_0A_00000101_0A_00000102_0A)
      $display("FAIL cont_bytes: got %0d bytes %h", n, got[119:0]);
    else passes++;
    checks++;
    if (busy !== 1'b0 || clr_n - b_clr != 3)
      $display("FAIL cont_stop: busy=%b clears=%0d required 0 3", busy, clr_n - b_clr);
    else passes++;
  endtask

  task automatic test_abort();
    int b_done, b_rx;
    b_done = done_n; b_rx = rx_q.size();
    cnt_val = 32'h55AA55AA;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    checks++;
    if (cnt_en !== 1'b1) $display("FAIL abort_in_gate: cnt_en=%b required 1", cnt_en);
    else passes++;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    checks++;
    if ({cnt_en, busy, tx_valid, cnt_clr} !== 4'b0)
      $display("FAIL abort_outputs: en/busy/valid/clr=%b required 0000",
               {cnt_en, busy, tx_valid, cnt_clr});
    else passes++;
    step(30);
    checks++;
    if (rx_q.size() != b_rx || done_n != b_done)
      $display("FAIL abort_silent: bytes=%0d dones=%0d required 0 0",
               rx_q.size() - b_rx, done_n - b_done);
    else passes++;
    checks++;
    if (last_count !== 32'h00000102)
      $display("FAIL abort_last_count: got %h required 00000102", last_count);
    else passes++;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cnt_clr !== 1'b0)
      $display("FAIL abort_idle_noop: busy=%b clr=%b required 0 0", busy, cnt_clr);
    else passes++;
  endtask

  task automatic test_reset_mid_send();
    int t0, b_done, b_rx, n;
    logic [127:0] got;
    cnt_val = 32'hCAFEF00D;
    tx_ready = 1'b1;
    b_rx = rx_q.size();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(16);
    checks++;
    if (rx_q.size() - b_rx != 2 || tx_data !== 8'hF0)
      $display("FAIL rst_send_pos: sent=%0d data=%h required 2 f0", rx_q.size() - b_rx, tx_data);
    else passes++;
    rst = 1'b1;
    tx_ready = 1'b0;
    step(1);
    rst = 1'b0;
    checks++;
    if ({cnt_clr, cnt_en, tx_valid, busy, done} !== 5'b0 || tx_data !== 8'h00 ||
        last_count !== 32'h0)
      $display("FAIL rst_send_outputs: flags=%b data=%h last=%h required 00000 00 0",
               {cnt_clr, cnt_en, tx_valid, busy, done}, tx_data, last_count);
    else passes++;
    tx_ready = 1'b1;
    b_done = done_n; b_rx = rx_q.size();
    t0 = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(b_done, 60);
    get_bytes(b_rx, got, n);
    checks++;
    if (n != 5 || got[39:0] !== 40'hCAFEF00D_0A || done_at - t0 != 20)
      $display("FAIL rst_fresh_frame: got %0d bytes %h latency %0d required 5 cafef00d0a 20",
               n, got[39:0], done_at - t0);
    else passes++;
  endtask

  task automatic test_start_held();
    int b_clr, b_done;
    cnt_val = 32'h0BADF00D;
    b_clr = clr_n; b_done = done_n;
    start = 1'b1;
    step(21);
    checks++;
    if (clr_n - b_clr != 1 || done_n - b_done != 1)
      $display("FAIL held_single: clears=%0d dones=%0d required 1 1",
               clr_n - b_clr, done_n - b_done);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL held_idle: busy=%b required 0", busy);
    else passes++;
    step(1);
    checks++;
    if (cnt_clr !== 1'b1) $display("FAIL held_restart: cnt_clr=%b required 1", cnt_clr);
    else passes++;
    start = 1'b0;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    cnt_val = 32'h0;
    test_reset();
    test_single();
    test_backpressure();
    test_continuous();
    test_abort();
    test_reset_mid_send();
    test_start_held();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/meas_sequencer.md
MEAS_SEQUENCER -- requirements
Module: meas_sequencer

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100000000, gate window length in clk_i cycles (1 s at 100 MHz).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, wait after gate close so the counter's synchronizer pipeline flushes.
REQ-003 SHALL have parameter CNT_W, default 32, measured count width (fixed at 32 for byte framing).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  system clock, all logic on rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 start_i  input  1  request one measurement; sampled only in IDLE.
REQ-008 cont_i  input  1  continuous mode; sampled only in DONE.
REQ-009 abort_i  input  1  cancel current measurement.
REQ-010 cnt_clr_o  output  1  clear pulse to the edge counter.
REQ-011 cnt_en_o  output  1  gate enable to the edge counter.
REQ-012 cnt_val_i  input  CNT_W  edge counter value.
REQ-013 tx_data_o  output  8  byte to UART transmitter.
REQ-014 tx_valid_o  output  1  tx_data_o valid.
REQ-015 tx_ready_i  input  1  UART transmitter can accept a byte.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 done_o  output  1  one-cycle pulse at measurement completion.
REQ-018 last_count_o  output  CNT_W  most recently latched count.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, GATE, SETTLE, LATCH, SEND, DONE.
REQ-020 IDLE -> CLEAR on the edge where start_i=1; otherwise remain.
REQ-021 CLEAR lasts exactly 1 cycle with cnt_clr_o=1, then GATE.
REQ-022 GATE lasts exactly GATE_CYCLES cycles with cnt_en_o=1; cnt_en_o=0 in all other states.
REQ-023 Gate cycle counter SHALL run 0..GATE_CYCLES-1 and reset to 0 on entering GATE; no wrap-around or off-by-one.
REQ-024 SETTLE lasts exactly SETTLE_CYCLES cycles; SETTLE_CYCLES=0 goes directly GATE -> LATCH.
REQ-025 LATCH lasts 1 cycle; cnt_val_i is captured into last_count_o on that cycle's closing edge.
REQ-026 SEND transmits 5 bytes in order: last_count_o[31:24], [23:16], [15:8], [7:0], then 0x0A.
REQ-027 A byte transfers on an edge where tx_valid_o=1 and tx_ready_i=1; the next byte is presented on the following cycle.
REQ-028 While tx_valid_o=1 and tx_ready_i=0, tx_data_o and tx_valid_o SHALL hold stable; an indefinite stall is legal.
REQ-029 tx_valid_o SHALL be 0 outside SEND.
REQ-030 After the 5th transfer SEND -> DONE; DONE lasts 1 cycle with done_o=1.
REQ-031 DONE -> CLEAR if cont_i=1, else IDLE.
REQ-032 start_i outside IDLE SHALL be ignored, not queued.
REQ-033 cont_i deasserted mid-measurement: current measurement completes and reports, then IDLE.
REQ-034 abort_i=1 in any non-IDLE state: next state IDLE; tx_valid_o, cnt_en_o and cnt_clr_o are 0 from the next cycle; last_count_o unchanged; no done_o.
REQ-035 abort_i has priority over start_i; abort_i in IDLE has no effect.
REQ-036 An abort during SEND may truncate the frame; this is permitted.
REQ-037 Minimum frame latency from start_i edge to done_o, with tx_ready_i=1 throughout: 1+GATE_CYCLES+SETTLE_CYCLES+1+5 cycles; done_o is high in the cycle after the last of these.

Reset
REQ-038 rst_i=1 SHALL force IDLE from any state, including mid-SEND, overriding all other inputs.
REQ-039 Reset values: cnt_clr_o=0, cnt_en_o=0, tx_data_o=0x00, tx_valid_o=0, busy_o=0, done_o=0, last_count_o=0, gate/settle/byte counters=0.

Verification (GATE_CYCLES=10, SETTLE_CYCLES=2)
REQ-040 Single shot: start_i pulse, cnt_val_i=0x12345678, tx_ready_i=1 -> cnt_clr_o 1 cycle; cnt_en_o exactly 10 cycles; bytes 12 34 56 78 0A; done_o 1 cycle at start+20; then IDLE with busy_o=0.
REQ-041 Backpressure: tx_ready_i low for 7 cycles on byte 2 -> tx_data_o=0x34 and tx_valid_o held; no byte lost or duplicated; done_o delayed by 7 cycles.
REQ-042 Continuous: cont_i=1, cnt_val_i increments per frame -> back-to-back frames with DONE->CLEAR and no IDLE cycle; clearing cont_i during GATE -> exactly one more frame, then IDLE.
REQ-043 Abort in GATE cycle 5 -> cnt_en_o 0 next cycle, IDLE, no bytes, no done_o, last_count_o keeps its previous value.
REQ-044 Sync reset mid-SEND after 2 bytes -> all outputs at reset values next cycle; a fresh start_i produces a complete 5-byte frame.
REQ-045 start_i held high throughout a measurement -> no second measurement begins until IDLE is reached.
